load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory stage directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address and rs2 as store data, and performs LB/LH/LW/LBU/LHU/SB/SH/SW against an internal word-organised memory.
- Returns load data for register-file writeback through a valid/ready handshake.
- The core stalls on busy, which makes the design multi-cycle at memory instructions.

Parameters:
- DEPTH_WORDS, 32, number of 32-bit memory words (power of two, ≥ 4).
- IDX_W, $clog2(DEPTH_WORDS), word-index width (derived, do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- req_valid  input  1  execute stage presents a memory op.
- req_ready  output  1  LSU accepts request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data (rs2).
- resp_valid  output  1  response available.
- resp_ready  input  1  writeback consumes response.
- resp_rdata  output  32  aligned, extended load data; 0 for stores.
- resp_misaligned  output  1  access faulted, no memory effect.
- busy  output  1  request in flight (state != IDLE).
- mem_check  output  32 x DEPTH_WORDS  live memory contents for benches.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, busy=0.
  - All memory words cleared to 0.
  - Reset mid-operation abandons the op; a store not yet in WRITE never commits.
- Word index = req_addr[IDX_W+1:2]; higher address bits ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Byte offset = req_addr[1:0].
- Request capture:
  - req_ready=1 only in IDLE.
  - Handshake on req_valid & req_ready at a rising edge; addr, funct3, write, wdata registered.
- Misalignment: H/HU with offset[0]=1, W with offset≠00. Funct3 values 011/110/111 are illegal and also flagged misaligned.
- States:
  - IDLE -> READ on accepted load; -> WRITE on accepted store; -> RESP on misaligned (with flag set).
  - READ: registers mem[index] -> RESP.
  - WRITE: commits the store using byte lanes at this edge -> RESP.
    - SB writes lane offset with wdata[7:0].
    - SH writes lanes offset..offset+1 with wdata[15:0].
    - SW writes all lanes.
  - RESP: resp_valid=1. Holds resp_rdata and resp_misaligned stable until resp_ready=1, then -> IDLE.
- Load extraction in RESP:
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Little-endian: byte at offset k = word[8k+7:8k].
- Latency:
  - Accept edge to resp_valid: 2 cycles for aligned loads and stores, 1 cycle for misaligned.
  - Back-to-back ops: next req_ready one cycle after the response handshake. Throughput is 1 op per 3 cycles minimum.
- resp_ready already high on RESP entry: response completes at the next edge.
- resp_rdata and resp_misaligned are cleared to 0 on return to IDLE.
- mem_check reflects memory after every edge; a store is visible one edge after WRITE.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: misaligned and illegal-funct3 requests behave as above (flagged, no memory access, no write).
- Undefined: resp_misaligned tied 0.
  - Misaligned addresses are forced down to natural alignment (H clears bit 0, W clears bits 1:0) and proceed through READ/WRITE normally.
  - Illegal funct3 is treated as W.

Test Plan:
1. Reset, SW addr 0x8 data 0xDEADBEEF -> resp_valid 2 cycles after accept, resp_rdata=0, mem_check[2]=0xDEADBEEF.
2. SW 0x4 data 0x80F17F01, then LB 0x5 -> 0x0000007F; LB 0x6 -> 0xFFFFFFF1; LBU 0x7 -> 0x00000080.
3. SW 0xC 0x12345678, then SB 0xD data 0xAA -> mem_check[3]=0x1234AA78; LH 0xE -> 0x00001234; LHU 0xC -> 0x0000AA78.
4. Hold resp_ready=0 for 3 cycles during LW 0x8 -> resp_valid and resp_rdata=0xDEADBEEF stable, req_ready=0, busy=1 throughout; release -> IDLE next edge.
5. With LSU_MISALIGN_TRAP_EN: SW 0x2 data 0xFFFFFFFF -> resp_misaligned=1 one cycle after accept, mem_check[0] unchanged. Without the macro: mem_check[0]=0xFFFFFFFF.
6. Assert reset low in WRITE of SW 0x10 -> immediate IDLE, all outputs 0, mem_check[4]=0. Also LW at address 4*DEPTH_WORDS+8 returns mem_check[2].

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory stage of the RV32I core. Takes the ALU result as a byte
//   address and rs2 as store data. It runs LB/LH/LW/LBU/LHU/SB/SH/SW against
//   an internal word-organised memory. Load data comes back through a
//   valid/ready response handshake.
//
//   Ports:
//     clk             rising-edge clock
//     reset           asynchronous active-low reset
//     req_valid/ready request handshake (ready only while idle)
//     req_write       1 = store, 0 = load
//     req_funct3      RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//     req_addr        byte address, wraps modulo 4*DEPTH_WORDS
//     req_wdata       store data
//     resp_valid/ready response handshake
//     resp_rdata      aligned, extended load data (0 for stores)
//     resp_misaligned access faulted, memory untouched
//     busy            an operation is in flight
//     mem_check       live view of every memory word
//
//   Build option LSU_MISALIGN_TRAP_EN:
//     defined   - misaligned or illegal-funct3 requests are flagged and skip
//                 the memory access.
//     undefined - resp_misaligned stays 0. Misaligned addresses are rounded
//                 down to natural alignment. Illegal funct3 acts as W.
module load_store_unit #(
  parameter  int DEPTH_WORDS = 32,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [2:0]                  req_funct3,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [31:0]                 resp_rdata,
  output logic                        resp_misaligned,
  output logic                        busy,
  output logic [DEPTH_WORDS-1:0][31:0] mem_check
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic [IDX_W+1:0]  addr_q,   addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q,  wdata_d;
  logic [31:0]       rdata_q,  rdata_d;
  logic              mis_q,    mis_d;
  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [31:0]       mem_d [DEPTH_WORDS];

  // Address bits above the memory span are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:IDX_W+2];

  // Request decode: fault detection plus the effective funct3/address used
  // once the request is captured.
  logic              req_fault;
  logic              eff_fault;
  logic [2:0]        eff_funct3;
  logic [IDX_W+1:0]  eff_addr;

  always_comb begin
    case (req_funct3)
      3'b000, 3'b100: req_fault = 1'b0;
      3'b001, 3'b101: req_fault = req_addr[0];
      3'b010:         req_fault = |req_addr[1:0];
      default:        req_fault = 1'b1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    eff_fault  = req_fault;
    eff_funct3 = req_funct3;
    eff_addr   = req_addr[IDX_W+1:0];
`else
    eff_fault  = 1'b0;
    eff_addr   = req_addr[IDX_W+1:0];
    case (req_funct3)
      3'b000, 3'b100: eff_funct3 = req_funct3;
      3'b001, 3'b101: begin
        eff_funct3  = req_funct3;
        eff_addr[0] = 1'b0;
      end
      default: begin
        // Word access, including the illegal encodings.
        eff_funct3    = 3'b010;
        eff_addr[1:0] = 2'b00;
      end
    endcase
`endif
  end

  // Load extraction: little-endian lane select, then sign or zero extend.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   extract = f3[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      2'b01:   extract = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  // Store lane enables and replicated data, so that every enabled lane
  // picks up its byte from the same position.
  logic [3:0]  store_be;
  logic [31:0] store_data;
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        store_be   = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        store_be   = 4'b0011 << addr_q[1:0];
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    mem_d    = mem_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = eff_addr;
          funct3_d = eff_funct3;
          wdata_d  = req_wdata;
          mis_d    = eff_fault;
          rdata_d  = 32'h0;
          state_d  = eff_fault ? S_RESP : (req_write ? S_WRITE : S_READ);
        end
      end
      S_READ: begin
        rdata_d = extract(mem_q[addr_q[IDX_W+1:2]], addr_q[1:0], funct3_q);
        state_d = S_RESP;
      end
      S_WRITE: begin
        for (int k = 0; k < 4; k++) begin
          if (store_be[k]) begin
            mem_d[addr_q[IDX_W+1:2]][8*k +: 8] = store_data[8*k +: 8];
          end
        end
        rdata_d = 32'h0;
        state_d = S_RESP;
      end
      default: begin
        if (resp_ready) begin
          rdata_d = 32'h0;
          mis_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      mis_q    <= 1'b0;
      for (int w = 0; w < DEPTH_WORDS; w++) mem_q[w] <= 32'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      mem_q    <= mem_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign resp_valid      = (state_q == S_RESP);
  assign resp_rdata      = rdata_q;
  assign resp_misaligned = mis_q;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH_WORDS; gi++) begin : g_mem_check
      assign mem_check[gi] = mem_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed table of load/store vectors with hand-computed results.
//   Hand-written sequences cover response back-pressure, misaligned access
//   (both build options) and reset in the middle of a store.
module tb_load_store_unit;

  localparam int DEPTH = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_misaligned;
  logic                  busy;
  logic [DEPTH-1:0][31:0] mem_check;

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .busy            (busy),
    .mem_check       (mem_check)
  );

  always #5 clk = ~clk;

  int vec_count  = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete operation with resp_ready held high.
  // lat = posedges from the accept edge (inclusive) until resp_valid is seen.
  task automatic do_op(input logic w, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic mis,
                       output int lat);
    @(negedge clk);
    check("req_ready idle", {31'b0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata;
    mis   = resp_misaligned;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          chk_idx;   // memory word to inspect afterwards, -1 = none
    logic [31:0] chk_val;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  logic [31:0] rd;
  logic        mis;
  int          lat;

  initial begin
    vecs[0]  = '{1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0,        2, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 3'b010, 32'h04, 32'h80F17F01, 32'h0,        1, 32'h80F17F01};
    vecs[2]  = '{1'b0, 3'b000, 32'h05, 32'h0,        32'h0000007F, -1, 32'h0};
    vecs[3]  = '{1'b0, 3'b000, 32'h06, 32'h0,        32'hFFFFFFF1, -1, 32'h0};
    vecs[4]  = '{1'b0, 3'b100, 32'h07, 32'h0,        32'h00000080, -1, 32'h0};
    vecs[5]  = '{1'b0, 3'b100, 32'h04, 32'h0,        32'h00000001, -1, 32'h0};
    vecs[6]  = '{1'b0, 3'b010, 32'h04, 32'h0,        32'h80F17F01, -1, 32'h0};
    vecs[7]  = '{1'b1, 3'b010, 32'h0C, 32'h12345678, 32'h0,        3, 32'h12345678};
    vecs[8]  = '{1'b1, 3'b000, 32'h0D, 32'h000000AA, 32'h0,        3, 32'h1234AA78};
    vecs[9]  = '{1'b0, 3'b001, 32'h0E, 32'h0,        32'h00001234, -1, 32'h0};
    vecs[10] = '{1'b0, 3'b101, 32'h0C, 32'h0,        32'h0000AA78, -1, 32'h0};
    vecs[11] = '{1'b0, 3'b001, 32'h0C, 32'h0,        32'hFFFFAA78, -1, 32'h0};
    vecs[12] = '{1'b0, 3'b000, 32'h0D, 32'h0,        32'hFFFFFFAA, -1, 32'h0};
    vecs[13] = '{1'b1, 3'b001, 32'h06, 32'h0000BEEF, 32'h0,        1, 32'hBEEF7F01};
    vecs[14] = '{1'b0, 3'b101, 32'h06, 32'h0,        32'h0000BEEF, -1, 32'h0};
    vecs[15] = '{1'b0, 3'b010, 32'h88, 32'h0,        32'hDEADBEEF, 2, 32'hDEADBEEF};

    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    #12;
    check("reset req_ready",  {31'b0, req_ready}, 32'h1);
    check("reset resp_valid", {31'b0, resp_valid}, 32'h0);
    check("reset busy",       {31'b0, busy}, 32'h0);
    check("reset rdata",      resp_rdata, 32'h0);
    check("reset mis",        {31'b0, resp_misaligned}, 32'h0);
    check("reset mem2",       mem_check[2], 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, mis, lat);
      $display("vec %0d: wr=%0d f3=%b addr=%h wdata=%h -> rdata=%h mis=%0d lat=%0d",
               i, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, mis, lat);
      check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d mis", i), {31'b0, mis}, 32'h0);
      check($sformatf("v%0d latency", i), lat, 32'd2);
      if (vecs[i].chk_idx >= 0)
        check($sformatf("v%0d mem", i), mem_check[vecs[i].chk_idx], vecs[i].chk_val);
    end

    // Back-pressure: LW 0x8 with resp_ready low for three cycles.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h8; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      $display("hold cycle %0d: valid=%0d rdata=%h ready=%0d busy=%0d",
               c, resp_valid, resp_rdata, req_ready, busy);
      check("hold resp_valid", {31'b0, resp_valid}, 32'h1);
      check("hold rdata",      resp_rdata, 32'hDEADBEEF);
      check("hold req_ready",  {31'b0, req_ready}, 32'h0);
      check("hold busy",       {31'b0, busy}, 32'h1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    $display("hold release: ready=%0d busy=%0d rdata=%h", req_ready, busy, resp_rdata);
    check("release req_ready", {31'b0, req_ready}, 32'h1);
    check("release busy",      {31'b0, busy}, 32'h0);
    check("release rdata",     resp_rdata, 32'h0);

    // Misaligned store SW 0x2, then misaligned LH 0x9 and illegal funct3 at 0x8.
    do_op(1'b1, 3'b010, 32'h2, 32'hFFFFFFFF, rd, mis, lat);
    $display("misaligned SW 0x2: mis=%0d lat=%0d mem0=%h", mis, lat, mem_check[0]);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis SW flag", {31'b0, mis}, 32'h1);
    check("mis SW lat",  lat, 32'd1);
    check("mis SW mem0", mem_check[0], 32'h0);
`else
    check("mis SW flag", {31'b0, mis}, 32'h0);
    check("mis SW lat",  lat, 32'd2);
    check("mis SW mem0", mem_check[0], 32'hFFFFFFFF);
`endif
    check("mis SW rdata", rd, 32'h0);

    do_op(1'b0, 3'b001, 32'h9, 32'h0, rd, mis, lat);
    $display("misaligned LH 0x9: rdata=%h mis=%0d lat=%0d", rd, mis, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis LH flag",  {31'b0, mis}, 32'h1);
    check("mis LH rdata", rd, 32'h0);
`else
    check("mis LH flag",  {31'b0, mis}, 32'h0);
    check("mis LH rdata", rd, 32'hFFFFBEEF);
`endif

    do_op(1'b0, 3'b011, 32'h8, 32'h0, rd, mis, lat);
    $display("illegal f3 0x8: rdata=%h mis=%0d lat=%0d", rd, mis, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    check("ill flag",  {31'b0, mis}, 32'h1);
    check("ill rdata", rd, 32'h0);
`else
    check("ill flag",  {31'b0, mis}, 32'h0);
    check("ill rdata", rd, 32'hDEADBEEF);
`endif

    // Reset while SW 0x10 sits in WRITE: the store must never commit.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h55AA55AA; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre-reset busy", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    $display("reset in WRITE: ready=%0d busy=%0d valid=%0d mem4=%h",
             req_ready, busy, resp_valid, mem_check[4]);
    check("rst req_ready",  {31'b0, req_ready}, 32'h1);
    check("rst busy",       {31'b0, busy}, 32'h0);
    check("rst resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst mem4",       mem_check[4], 32'h0);
    check("rst mem2",       mem_check[2], 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst mem4", mem_check[4], 32'h0);
    do_op(1'b0, 3'b010, 32'h10, 32'h0, rd, mis, lat);
    $display("LW 0x10 after reset: rdata=%h", rd);
    check("post-rst LW", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
